// File: rtl/gray_arb_pkg.sv
// Shared types and sizing helpers for the gray-frame arbiter slice.
package gray_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } arb_state_e;

   localparam int unsigned N_SRC           = 2;
   localparam int unsigned BYTES_PER_PIXEL = 3;

   // Bits needed to hold a count 0..n-1 (never less than one bit).
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with head-of-queue visibility; DEPTH must be a power of 2.
module sync_fifo
   import gray_arb_pkg::*;
#(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int unsigned AW = cnt_width(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge i_clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointer and occupancy tracking; simultaneous push and pop leaves count unchanged.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/gray_frame_arbiter.sv
// Frame-granular round-robin arbiter in front of a shared RGB-to-gray datapath,
// tagging returning gray bytes with the source that owned each frame.
module gray_frame_arbiter
   import gray_arb_pkg::*;
#(
   parameter int unsigned C_FRAME_PIXELS = 64,
   parameter int unsigned C_TAG_DEPTH    = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [N_SRC*8-1:0]   s_data,
   input  logic [N_SRC-1:0]     s_valid,
   input  logic [N_SRC-1:0]     s_sof,
   output logic [N_SRC-1:0]     s_busy,
   output logic [7:0]           m_data,
   output logic                 m_valid,
   output logic                 m_sof,
   input  logic                 m_busy,
   input  logic [7:0]           r_data,
   input  logic                 r_valid,
   input  logic                 r_sof,
   output logic                 r_busy,
   output logic [7:0]           o_data,
   output logic                 o_valid,
   output logic                 o_sof,
   output logic                 o_src,
   input  logic                 i_busy,
   output logic [N_SRC-1:0]     o_drop,
   output logic                 o_err
);

   localparam int unsigned IN_BYTES = BYTES_PER_PIXEL * C_FRAME_PIXELS;
   localparam int unsigned BCW      = cnt_width(IN_BYTES);
   localparam int unsigned RCW      = cnt_width(C_FRAME_PIXELS);

   arb_state_e       state;
   logic             owner;
   logic             last_src;
   logic [BCW-1:0]   bcnt;
   logic [RCW-1:0]   rcnt;
   logic [N_SRC-1:0] drop_q;
   logic             err_q;

   logic [N_SRC-1:0] cand;
   logic             grant;
   logic             grant_src;
   logic             first_byte;
   logic             last_byte;
   logic             m_acc;
   logic             tag_push;
   logic             tag_pop;
   logic             tag_full;
   logic             tag_empty;
   logic             tag_head;
   logic             r_acc;
   logic             r_orphan;

   // Grant decision: a tie goes to the source that did not own the previous frame.
   assign cand      = s_valid & s_sof;
   assign grant     = (state == IDLE) && !tag_full && (cand != '0);
   assign grant_src = (&cand) ? ~last_src : cand[1];

   // Input side: owner's stream passes straight through while in XFER.
   assign first_byte = (bcnt == '0);
   assign last_byte  = (bcnt == BCW'(IN_BYTES - 1));
   assign m_data     = owner ? s_data[15:8] : s_data[7:0];
   assign m_valid    = i_rst_n && (state == XFER) && s_valid[owner];
   assign m_sof      = m_valid && s_sof[owner] && first_byte;
   assign m_acc      = m_valid && !m_busy;
   assign tag_push   = m_acc && first_byte;

   always_comb begin
      s_busy = '1;
      if (i_rst_n) begin
         if (state == IDLE) s_busy = s_sof;
         else               s_busy[owner] = m_busy;
      end
   end

   // Result side: label bytes with the oldest in-flight tag; bytes with no tag are orphans.
   assign r_busy   = i_busy;
   assign o_data   = r_data;
   assign o_sof    = r_sof;
   assign o_src    = tag_head;
   assign o_valid  = i_rst_n && r_valid && !tag_empty;
   assign r_acc    = r_valid && !i_busy && !tag_empty;
   assign r_orphan = r_valid && !i_busy && tag_empty;
   assign tag_pop  = r_acc && (rcnt == RCW'(C_FRAME_PIXELS - 1));

   assign o_drop = drop_q;
   assign o_err  = err_q;

   sync_fifo #(
      .WIDTH (1),
      .DEPTH (C_TAG_DEPTH)
   ) u_tag_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .push    (tag_push),
      .pop     (tag_pop),
      .din     (owner),
      .full    (tag_full),
      .empty   (tag_empty),
      .head    (tag_head)
   );

   // Frame FSM, byte/result counters and event pulses.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state    <= IDLE;
         owner    <= 1'b0;
         last_src <= 1'b1;
         bcnt     <= '0;
         rcnt     <= '0;
         drop_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         drop_q <= (state == IDLE) ? (s_valid & ~s_sof) : '0;
         err_q  <= (m_acc && !first_byte && s_sof[owner]) || r_orphan;

         case (state)
            IDLE: begin
               if (grant) begin
                  owner <= grant_src;
                  state <= XFER;
               end
            end
            XFER: begin
               if (m_acc) begin
                  if (last_byte) begin
                     bcnt     <= '0;
                     last_src <= owner;
                     state    <= IDLE;
                  end else begin
                     bcnt <= bcnt + BCW'(1);
                  end
               end
            end
         endcase

         if (r_acc) rcnt <= tag_pop ? '0 : rcnt + RCW'(1);
      end
   end

endmodule

// File: tb/tb_gray_frame_arbiter.sv
// Randomized and directed bench for gray_frame_arbiter with a queue-based reference model.
module tb_gray_frame_arbiter;

   localparam int unsigned P  = 2;
   localparam int unsigned D  = 2;
   localparam int          FB = 6;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic [15:0] s_data;
   logic [1:0]  s_valid, s_sof, s_busy;
   logic [7:0]  m_data;
   logic        m_valid, m_sof, m_busy;
   logic [7:0]  r_data;
   logic        r_valid, r_sof, r_busy;
   logic [7:0]  o_data;
   logic        o_valid, o_sof, o_src, i_busy;
   logic [1:0]  o_drop;
   logic        o_err;

   always #5 i_clk = ~i_clk;

   gray_frame_arbiter #(.C_FRAME_PIXELS(P), .C_TAG_DEPTH(D)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .s_data(s_data), .s_valid(s_valid), .s_sof(s_sof), .s_busy(s_busy),
      .m_data(m_data), .m_valid(m_valid), .m_sof(m_sof), .m_busy(m_busy),
      .r_data(r_data), .r_valid(r_valid), .r_sof(r_sof), .r_busy(r_busy),
      .o_data(o_data), .o_valid(o_valid), .o_sof(o_sof), .o_src(o_src),
      .i_busy(i_busy), .o_drop(o_drop), .o_err(o_err)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Stimulus state: directed byte scripts (bit8 = sof) or random producers.
   bit rand_mode = 0;
   int sq0[$], sq1[$], rq[$];
   int mb_hold = 0;
   int pos[2];
   int pending = 0, rpos = 0, rand_acc = 0;

   // Observation logs.
   int acc_log[$], acc_cyc[$], res_log[$], res_cyc[$];
   int m_acc_cnt = 0, drop0_cnt = 0, drop1_cnt = 0, err_cnt = 0;

   initial begin
      int e;
      logic [1:0] cons;
      s_valid = '0; s_sof = '0; s_data = '0; m_busy = 0;
      r_valid = 0; r_sof = 0; r_data = '0; i_busy = 0;
      forever begin
         @(negedge i_clk);
         if (o_drop[0]) drop0_cnt++;
         if (o_drop[1]) drop1_cnt++;
         if (o_err)     err_cnt++;
         if (i_rst_n) begin
            cons = s_valid & ~s_busy;
            if (m_valid && !m_busy) begin
               acc_log.push_back(int'(m_data));
               acc_cyc.push_back(cyc);
               m_acc_cnt++;
               if (rand_mode) begin
                  rand_acc++;
                  if (rand_acc % FB == 0) pending++;
               end
            end
            if (o_valid && !i_busy) begin
               res_log.push_back((int'(o_src) << 9) | (int'(o_sof) << 8) | int'(o_data));
               res_cyc.push_back(cyc);
            end
            if (rand_mode) begin
               for (int i = 0; i < 2; i++) if (cons[i]) pos[i] = (pos[i] + 1) % FB;
               if (r_valid && !i_busy) begin
                  if (rpos == 0) pending--;
                  rpos = (rpos + 1) % P;
               end
            end else begin
               if (cons[0] && sq0.size() > 0) void'(sq0.pop_front());
               if (cons[1] && sq1.size() > 0) void'(sq1.pop_front());
               if (r_valid && !i_busy && rq.size() > 0) void'(rq.pop_front());
            end
         end
         @(posedge i_clk);
         #1;
         if (rand_mode) begin
            for (int i = 0; i < 2; i++) begin
               s_valid[i] = ($urandom_range(0, 9) < 7);
               s_sof[i]   = (pos[i] == 0) ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 29) == 0);
            end
            s_data  = 16'($urandom);
            m_busy  = ($urandom_range(0, 3) == 0);
            i_busy  = ($urandom_range(0, 3) == 0);
            r_valid = (rpos > 0 || pending > 0) && ($urandom_range(0, 9) < 7);
            r_sof   = (rpos == 0);
            r_data  = 8'($urandom);
         end else begin
            e = (sq0.size() > 0) ? sq0[0] : 0;
            s_valid[0] = (sq0.size() > 0); s_sof[0] = e[8]; s_data[7:0] = e[7:0];
            e = (sq1.size() > 0) ? sq1[0] : 0;
            s_valid[1] = (sq1.size() > 0); s_sof[1] = e[8]; s_data[15:8] = e[7:0];
            m_busy = (mb_hold > 0);
            if (mb_hold > 0) mb_hold--;
            i_busy = 0;
            e = (rq.size() > 0) ? rq[0] : 0;
            r_valid = (rq.size() > 0); r_sof = e[8]; r_data = e[7:0];
         end
      end
   end

   // Reference model: frame ownership as an int, in-flight owners as a queue.
   bit   md_started = 0, md_xfer = 0, md_err = 0;
   int   md_own = 0, md_last = 1, md_bc = 0, md_rc = 0;
   int   md_tags[$];
   logic [1:0] md_drop = '0;

   initial begin
      int   push_src;
      bit   c0, c1, nerr;
      logic [1:0] ndrop;
      forever begin
         @(negedge i_clk);
         if (md_started) begin
            if (!i_rst_n) begin
               chk("rst_s_busy", s_busy, 3);
               chk("rst_m_valid", m_valid, 0);
               chk("rst_o_valid", o_valid, 0);
            end else begin
               if (!md_xfer) begin
                  for (int i = 0; i < 2; i++)
                     if (s_valid[i]) chk("idle_s_busy", s_busy[i], s_sof[i]);
                  chk("idle_m_valid", m_valid, 0);
               end else begin
                  chk("m_valid", m_valid, s_valid[md_own]);
                  if (s_valid[md_own]) begin
                     chk("m_data", m_data, md_own ? s_data[15:8] : s_data[7:0]);
                     chk("m_sof", m_sof, s_sof[md_own] && md_bc == 0);
                  end
                  chk("s_busy_owner", s_busy[md_own], m_busy);
                  chk("s_busy_other", s_busy[1-md_own], 1);
               end
               chk("o_valid", o_valid, r_valid && md_tags.size() > 0);
               if (r_valid && md_tags.size() > 0) begin
                  chk("o_data", o_data, r_data);
                  chk("o_sof", o_sof, r_sof);
                  chk("o_src", o_src, md_tags[0]);
               end
               chk("r_busy", r_busy, i_busy);
            end
            chk("o_drop", o_drop, md_drop);
            chk("o_err", o_err, md_err);
         end
         @(posedge i_clk);
         if (!i_rst_n) begin
            md_started = 1; md_xfer = 0; md_own = 0; md_last = 1;
            md_bc = 0; md_rc = 0; md_tags.delete(); md_drop = '0; md_err = 0;
         end else if (md_started) begin
            ndrop = '0; nerr = 0; push_src = -1;
            if (!md_xfer) begin
               ndrop = s_valid & ~s_sof;
               c0 = s_valid[0] && s_sof[0];
               c1 = s_valid[1] && s_sof[1];
               if ((c0 || c1) && md_tags.size() < D) begin
                  md_own  = (c0 && c1) ? 1 - md_last : (c1 ? 1 : 0);
                  md_xfer = 1;
                  md_bc   = 0;
               end
            end else if (s_valid[md_own] && !m_busy) begin
               if (md_bc == 0) push_src = md_own;
               else if (s_sof[md_own]) nerr = 1;
               md_bc++;
               if (md_bc == FB) begin
                  md_xfer = 0; md_last = md_own; md_bc = 0;
               end
            end
            if (r_valid && !i_busy) begin
               if (md_tags.size() == 0) nerr = 1;
               else begin
                  md_rc++;
                  if (md_rc == P) begin
                     void'(md_tags.pop_front());
                     md_rc = 0;
                  end
               end
            end
            if (push_src >= 0) md_tags.push_back(push_src);
            md_drop = ndrop;
            md_err  = nerr;
         end
      end
   end

   task automatic clr_logs();
      acc_log.delete(); acc_cyc.delete(); res_log.delete(); res_cyc.delete();
   endtask

   task automatic do_reset();
      @(posedge i_clk); #1 i_rst_n = 0;
      @(negedge i_clk);
      chk("reset_s_busy_lit", s_busy, 2'b11);
      chk("reset_m_valid_lit", m_valid, 0);
      @(posedge i_clk); #1 i_rst_n = 1;
      @(negedge i_clk);
      chk("reset_drop_lit", o_drop, 0);
      chk("reset_err_lit", o_err, 0);
   endtask

   task automatic push_frame(input int src, input int base);
      for (int i = 0; i < FB; i++) begin
         if (src == 0) sq0.push_back(((i == 0) ? 256 : 0) | (base + i));
         else          sq1.push_back(((i == 0) ? 256 : 0) | (base + i));
      end
   endtask

   task automatic push_results(input int n);
      for (int i = 0; i < n; i++) rq.push_back(((i % P == 0) ? 256 : 0) | (8'hC0 + i));
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((sq0.size() + sq1.size() + rq.size()) > 0 && n < 300) begin
         @(posedge i_clk); n++;
      end
      chk(name, int'(n < 300), 1);
      repeat (3) @(posedge i_clk);
   endtask

   task automatic wait_acc(input int target, input string name);
      int n = 0;
      while (m_acc_cnt < target && n < 300) begin
         @(posedge i_clk); n++;
      end
      chk(name, int'(n < 300), 1);
   endtask

   initial begin
      int base;
      i_rst_n = 0;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      chk("init_s_busy_lit", s_busy, 2'b11);
      chk("init_o_valid_lit", o_valid, 0);
      @(posedge i_clk); #1 i_rst_n = 1;
      repeat (2) @(posedge i_clk);

      // Single frame on source 0, then its two results.
      clr_logs();
      push_frame(0, 8'hA0);
      wait_drain("s1_drain");
      chk("s1_acc_count", acc_log.size(), 6);
      for (int i = 0; i < 6 && i < acc_log.size(); i++) chk("s1_acc_data", acc_log[i], 8'hA0 + i);
      push_results(2);
      wait_drain("s1_res_drain");
      chk("s1_res_count", res_log.size(), 2);
      if (res_log.size() == 2) begin
         chk("s1_res0", res_log[0], 32'h1C0);
         chk("s1_res1", res_log[1], 32'h0C1);
      end

      // Simultaneous SOF after reset: source 0 first, one bubble, then source 1.
      do_reset();
      clr_logs();
      push_frame(0, 8'h00);
      push_frame(1, 8'h10);
      wait_drain("s2_drain");
      chk("s2_acc_count", acc_log.size(), 12);
      for (int i = 0; i < 12 && i < acc_log.size(); i++)
         chk("s2_acc_data", acc_log[i], (i < 6) ? i : 8'h10 + i - 6);
      if (acc_cyc.size() == 12) begin
         chk("s2_bubble", acc_cyc[6] - acc_cyc[5], 2);
         chk("s2_span", acc_cyc[11] - acc_cyc[0], 12);
      end
      push_results(4);
      wait_drain("s2_res_drain");
      chk("s2_res_count", res_log.size(), 4);
      for (int i = 0; i < 4 && i < res_log.size(); i++) chk("s2_res_src", res_log[i] >> 9, (i < 2) ? 0 : 1);

      // Non-SOF bytes on source 1 in IDLE are dropped; the following SOF is granted.
      clr_logs();
      drop0_cnt = 0; drop1_cnt = 0;
      sq1.push_back(8'h11);
      sq1.push_back(8'h22);
      push_frame(1, 8'h30);
      wait_drain("s3_drain");
      chk("s3_drop1", drop1_cnt, 2);
      chk("s3_drop0", drop0_cnt, 0);
      chk("s3_acc_count", acc_log.size(), 6);
      for (int i = 0; i < 6 && i < acc_log.size(); i++) chk("s3_acc_data", acc_log[i], 8'h30 + i);
      push_results(2);
      wait_drain("s3_res_drain");

      // Datapath stall of three cycles mid-frame.
      clr_logs();
      base = m_acc_cnt;
      push_frame(0, 8'h40);
      wait_acc(base + 2, "s4_wait");
      mb_hold = 3;
      wait_drain("s4_drain");
      chk("s4_acc_count", acc_log.size(), 6);
      for (int i = 0; i < 6 && i < acc_log.size(); i++) chk("s4_acc_data", acc_log[i], 8'h40 + i);
      if (acc_cyc.size() == 6) chk("s4_span", acc_cyc[5] - acc_cyc[0], 8);
      push_results(2);
      wait_drain("s4_res_drain");

      // Three back-to-back frames: the third waits for a tag to free up.
      clr_logs();
      base = m_acc_cnt;
      push_frame(0, 8'h50);
      push_frame(0, 8'h56);
      push_frame(0, 8'h5C);
      wait_acc(base + 12, "s5_wait");
      repeat (6) @(posedge i_clk);
      chk("s5_blocked", m_acc_cnt - base, 12);
      push_results(2);
      wait_acc(base + 13, "s5_resume");
      if (acc_cyc.size() > 12 && res_cyc.size() > 1) chk("s5_resume_lat", acc_cyc[12] - res_cyc[1], 2);
      wait_drain("s5_drain");
      chk("s5_total", m_acc_cnt - base, 18);
      push_results(4);
      wait_drain("s5_res_drain");
      chk("s5_res_count", res_log.size(), 6);

      // Reset at input byte 3, then an orphan result byte.
      base = m_acc_cnt;
      push_frame(0, 8'h60);
      wait_acc(base + 3, "s6_wait");
      #1 i_rst_n = 0;
      sq0.delete();
      @(negedge i_clk);
      chk("s6_rst_busy", s_busy, 2'b11);
      @(posedge i_clk);
      @(posedge i_clk); #1 i_rst_n = 1;
      repeat (2) @(posedge i_clk);
      clr_logs();
      base = err_cnt;
      rq.push_back(256 | 8'h77);
      wait_drain("s6_drain");
      chk("s6_orphan_err", err_cnt - base, 1);
      chk("s6_orphan_valid", res_log.size(), 0);

      // Randomized traffic.
      do_reset();
      pos[0] = 0; pos[1] = 0; pending = 0; rpos = 0; rand_acc = 0;
      base = m_acc_cnt;
      @(posedge i_clk);
      rand_mode = 1;
      repeat (3000) @(posedge i_clk);
      rand_mode = 0;
      repeat (2) @(posedge i_clk);
      chk("rand_activity", int'(m_acc_cnt - base > 200), 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
